fpdp_multiplication: RTL

- Sequential IEEE 754 binary64 multiplier; the inverse operation of the existing fpdp_division unit.
- Companion datapath for the Nth-root iteration, which needs both x^k products and quotients.
- Uses the same ready/done operand handshake as the divider, so the root controller drives both units identically.
- Mantissa product is formed by an iterative shift-add, one multiplier bit per clock.

---
 rtl/fpdp_pkg.sv | 45 ++++
 rtl/fpdp_multiplication_if.sv | 32 +++
 rtl/fpdp_mant_mult.sv | 60 ++++++
 rtl/fpdp_multiplication.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fpdp_pkg.sv
// fpdp_pkg
// Shared binary64 constants, FSM state encodings and small packing helpers
// for the fpdp_* arithmetic units (multiplier now, divider on its next
// revision). No ports; imported with `import fpdp_pkg::*;`.
package fpdp_pkg;

    localparam int EXP_BIAS  = 1023;
    localparam int EXP_W     = 11;
    localparam int FRAC_W    = 52;
    localparam int MANT_W    = 53;
    // Unbiased exponents are carried signed in 13 bits: wide enough for the
    // sum of two normalised subnormal exponents (-2148) plus rounding carries.
    localparam int EXP_INT_W = 13;
    localparam int PROD_W    = 2 * MANT_W;

    localparam logic [63:0] QNAN = 64'hFFF8_0000_0000_0000;

    localparam logic signed [EXP_INT_W-1:0] EXP_MIN        = -13'sd1022;
    localparam logic signed [EXP_INT_W-1:0] EXP_MAX        = 13'sd1023;
    localparam logic signed [EXP_INT_W-1:0] EXP_FIELD_ONES = 13'sd1024;
    localparam logic signed [EXP_INT_W-1:0] EXP_FIELD_ZERO = -13'sd1023;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_UNPACK  = 4'd1;
    localparam state_t ST_SPECIAL = 4'd2;
    localparam state_t ST_NORM_A  = 4'd3;
    localparam state_t ST_NORM_B  = 4'd4;
    localparam state_t ST_MULT    = 4'd5;
    localparam state_t ST_NORM_1  = 4'd6;
    localparam state_t ST_NORM_2  = 4'd7;
    localparam state_t ST_ROUND   = 4'd8;
    localparam state_t ST_PACK    = 4'd9;
    localparam state_t ST_OUT     = 4'd10;

    function automatic logic [63:0] signedInf(input logic sign);
        return {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    endfunction

    function automatic logic [63:0] signedZero(input logic sign);
        return {sign, {(EXP_W + FRAC_W){1'b0}}};
    endfunction

endpackage

// File: rtl/fpdp_multiplication_if.sv
// fpdp_multiplication_if
// Operand/result handshake shared by the fpdp_* units.
//   fpdp_multiplicand, fpdp_multiplier : 64-bit operands (master -> unit)
//   ready                              : 4-bit start request, 'd1 starts
//   fpdp_product                       : 64-bit result (unit -> master)
//   done                               : 4-bit, 'd1 for one cycle per result
// master modport is the controller side, slave modport the arithmetic unit.
interface fpdp_multiplication_if;

    logic [63:0] fpdp_multiplicand;
    logic [63:0] fpdp_multiplier;
    logic [3:0]  ready;
    logic [63:0] fpdp_product;
    logic [3:0]  done;

    modport master (
        output fpdp_multiplicand,
        output fpdp_multiplier,
        output ready,
        input  fpdp_product,
        input  done
    );

    modport slave (
        input  fpdp_multiplicand,
        input  fpdp_multiplier,
        input  ready,
        output fpdp_product,
        output done
    );

endinterface

// File: rtl/fpdp_mant_mult.sv
// fpdp_mant_mult
// Iterative 53x53 unsigned shift-add multiplier, one multiplier bit per clock.
//   clk, rset      : clock, asynchronous active-low reset
//   i_start        : load operands and clear the accumulator
//   i_multiplicand : 53-bit mantissa a
//   i_multiplier   : 53-bit mantissa b
//   o_busy         : accumulating
//   o_valid        : the add on the coming edge is the last one; o_product
//                    holds the full 106-bit product right after that edge
//   o_product      : 106-bit accumulator
module fpdp_mant_mult
    import fpdp_pkg::*;
(
    input  logic              clk,
    input  logic              rset,
    input  logic              i_start,
    input  logic [MANT_W-1:0] i_multiplicand,
    input  logic [MANT_W-1:0] i_multiplier,
    output logic              o_busy,
    output logic              o_valid,
    output logic [PROD_W-1:0] o_product
);

    logic [PROD_W-1:0] r_acc;
    logic [PROD_W-1:0] r_mcand;
    logic [MANT_W-1:0] r_mplier;
    logic [5:0]        r_count;
    logic              r_busy;

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{(PROD_W - MANT_W){1'b0}}, i_multiplicand};
            r_mplier <= i_multiplier;
            r_count  <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 6'd1;
            if (r_count == 6'(MANT_W - 1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_valid   = r_busy && (r_count == 6'(MANT_W - 1));
    assign o_product = r_acc;

endmodule

// File: rtl/fpdp_multiplication.sv
// fpdp_multiplication
// Sequential IEEE 754 binary64 multiplier (round to nearest, ties to even).
//   clk    : rising-edge clock
//   rset   : asynchronous active-low reset, aborts any operation
//   io_bus : slave side of fpdp_multiplication_if
//            (operands + ready in, fpdp_product + done out)
// Mantissa product comes from fpdp_mant_mult; normalise/round/pack live here.
module fpdp_multiplication
    import fpdp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rset,
    fpdp_multiplication_if.slave  io_bus
);

    state_t                       r_state;
    logic [63:0]                  r_a, r_b, r_z, r_product;
    logic [3:0]                   r_done;
    logic                         r_aSign, r_bSign;
    logic signed [EXP_INT_W-1:0]  r_aExp, r_bExp, r_zExp;
    logic [MANT_W-1:0]            r_aMant, r_bMant, r_zMant;
    logic                         r_guard, r_round, r_sticky;

    logic                         w_zSign;
    logic                         w_aFracZero, w_bFracZero;
    logic                         w_aNan, w_bNan, w_aInf, w_bInf, w_aZero, w_bZero;
    logic                         w_roundUp;
    logic                         w_mulStart, w_mulBusy, w_mulValid;
    logic [PROD_W-1:0]            w_mulProduct;

    // Operand classes, meaningful while in SPECIAL (hidden bit still clear).
    assign w_zSign     = r_aSign ^ r_bSign;
    assign w_aFracZero = (r_aMant[FRAC_W-1:0] == '0);
    assign w_bFracZero = (r_bMant[FRAC_W-1:0] == '0);
    assign w_aNan      = (r_aExp == EXP_FIELD_ONES) && !w_aFracZero;
    assign w_bNan      = (r_bExp == EXP_FIELD_ONES) && !w_bFracZero;
    assign w_aInf      = (r_aExp == EXP_FIELD_ONES) && w_aFracZero;
    assign w_bInf      = (r_bExp == EXP_FIELD_ONES) && w_bFracZero;
    assign w_aZero     = (r_aExp == EXP_FIELD_ZERO) && w_aFracZero;
    assign w_bZero     = (r_bExp == EXP_FIELD_ZERO) && w_bFracZero;

    assign w_roundUp   = r_guard && (r_round || r_sticky || r_zMant[0]);

    // Start is combinational so the shift-add begins on the same edge the
    // FSM enters MULT; that keeps MULT at exactly 53 cycles.
    assign w_mulStart  = (r_state == ST_NORM_B) && r_bMant[MANT_W-1] && !w_mulBusy;

    fpdp_mant_mult u_mantMult (
        .clk            (clk),
        .rset           (rset),
        .i_start        (w_mulStart),
        .i_multiplicand (r_aMant),
        .i_multiplier   (r_bMant),
        .o_busy         (w_mulBusy),
        .o_valid        (w_mulValid),
        .o_product      (w_mulProduct)
    );

    assign io_bus.fpdp_product = r_product;
    assign io_bus.done         = r_done;

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_z       <= '0;
            r_product <= '0;
            r_done    <= 4'd0;
            r_aSign   <= 1'b0;
            r_bSign   <= 1'b0;
            r_aExp    <= '0;
            r_bExp    <= '0;
            r_zExp    <= '0;
            r_aMant   <= '0;
            r_bMant   <= '0;
            r_zMant   <= '0;
            r_guard   <= 1'b0;
            r_round   <= 1'b0;
            r_sticky  <= 1'b0;
        end else begin
            r_done <= 4'd0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.ready == 4'd1) begin
                        r_a     <= io_bus.fpdp_multiplicand;
                        r_b     <= io_bus.fpdp_multiplier;
                        r_state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    r_aSign <= r_a[63];
                    r_bSign <= r_b[63];
                    r_aExp  <= $signed({2'b00, r_a[62:52]}) - 13'(EXP_BIAS);
                    r_bExp  <= $signed({2'b00, r_b[62:52]}) - 13'(EXP_BIAS);
                    r_aMant <= {1'b0, r_a[FRAC_W-1:0]};
                    r_bMant <= {1'b0, r_b[FRAC_W-1:0]};
                    r_state <= ST_SPECIAL;
                end
                ST_SPECIAL: begin
                    if (w_aNan || w_bNan) begin
                        r_z     <= QNAN;
                        r_state <= ST_OUT;
                    end else if ((w_aInf && w_bZero) || (w_bInf && w_aZero)) begin
                        r_z     <= QNAN;
                        r_state <= ST_OUT;
                    end else if (w_aInf || w_bInf) begin
                        r_z     <= signedInf(w_zSign);
                        r_state <= ST_OUT;
                    end else if (w_aZero || w_bZero) begin
                        r_z     <= signedZero(w_zSign);
                        r_state <= ST_OUT;
                    end else begin
                        // Subnormals keep hidden bit 0 and take the minimum exponent.
                        if (r_aExp == EXP_FIELD_ZERO) r_aExp <= EXP_MIN;
                        else                          r_aMant[MANT_W-1] <= 1'b1;
                        if (r_bExp == EXP_FIELD_ZERO) r_bExp <= EXP_MIN;
                        else                          r_bMant[MANT_W-1] <= 1'b1;
                        r_state <= ST_NORM_A;
                    end
                end
                ST_NORM_A: begin
                    if (r_aMant[MANT_W-1]) begin
                        r_state <= ST_NORM_B;
                    end else begin
                        r_aMant <= r_aMant << 1;
                        r_aExp  <= r_aExp - 13'sd1;
                    end
                end
                ST_NORM_B: begin
                    if (w_mulStart) begin
                        r_zExp  <= r_aExp + r_bExp;
                        r_state <= ST_MULT;
                    end else if (!r_bMant[MANT_W-1]) begin
                        r_bMant <= r_bMant << 1;
                        r_bExp  <= r_bExp - 13'sd1;
                    end
                end
                ST_MULT: begin
                    if (w_mulValid) r_state <= ST_NORM_1;
                end
                ST_NORM_1: begin
                    // Product of two [1,2) mantissas lies in [1,4): leading one at bit 104 or 105.
                    if (w_mulProduct[PROD_W-1]) begin
                        r_zMant  <= w_mulProduct[105:53];
                        r_guard  <= w_mulProduct[52];
                        r_round  <= w_mulProduct[51];
                        r_sticky <= |w_mulProduct[50:0];
                        r_zExp   <= r_zExp + 13'sd1;
                    end else begin
                        r_zMant  <= w_mulProduct[104:52];
                        r_guard  <= w_mulProduct[51];
                        r_round  <= w_mulProduct[50];
                        r_sticky <= |w_mulProduct[49:0];
                    end
                    r_state <= ST_NORM_2;
                end
                ST_NORM_2: begin
                    if (r_zExp < EXP_MIN) begin
                        r_zMant  <= r_zMant >> 1;
                        r_guard  <= r_zMant[0];
                        r_round  <= r_guard;
                        r_sticky <= r_sticky | r_round;
                        r_zExp   <= r_zExp + 13'sd1;
                    end else begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (w_roundUp) begin
                        // All-ones mantissa carries out: becomes 1.0 at the next exponent.
                        if (&r_zMant) begin
                            r_zMant <= {1'b1, {FRAC_W{1'b0}}};
                            r_zExp  <= r_zExp + 13'sd1;
                        end else begin
                            r_zMant <= r_zMant + 53'd1;
                        end
                    end
                    r_state <= ST_PACK;
                end
                ST_PACK: begin
                    if (r_zExp > EXP_MAX) begin
                        r_z <= signedInf(w_zSign);
                    end else if ((r_zExp == EXP_MIN) && !r_zMant[MANT_W-1]) begin
                        r_z <= {w_zSign, {EXP_W{1'b0}}, r_zMant[FRAC_W-1:0]};
                    end else begin
                        r_z <= {w_zSign, 11'(r_zExp + 13'(EXP_BIAS)), r_zMant[FRAC_W-1:0]};
                    end
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    r_product <= r_z;
                    r_done    <= 4'd1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
